gray_updown_counter: RTL and testbench

- Parametrised WIDTH-bit up/down counter with an internal clock-enable prescaler. Reports its count as Gray or plain binary, selectable at run time.
- Supports synchronous load and a terminal-count pulse on wrap.
- Drives board LEDs/displays at human-visible rates, or provides glitch-free Gray-coded position to other logic.

---
 rtl/gray_pkg.sv | 25 ++
 rtl/gray_updown_counter_if.sv | 23 ++
 rtl/gray_updown_counter_clk_enable_gen.sv | 39 +++
 rtl/gray_updown_counter.sv | 69 ++++++
 tb/tb_gray_updown_counter.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/gray_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// gray_pkg : Gray/binary conversion helpers shared by counters and checkers
// Rev 1.0
// ----------------------------------------------------------------------------
package gray_pkg;

  localparam int c_MAX_W = 32;

  // Callers zero-extend to c_MAX_W and cast the result back to their width.
  function automatic logic [c_MAX_W-1:0] bin2gray(input logic [c_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [c_MAX_W-1:0] gray2bin(input logic [c_MAX_W-1:0] g);
    logic [c_MAX_W-1:0] b;
    b[c_MAX_W-1] = g[c_MAX_W-1];
    for (int i = c_MAX_W-2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/gray_updown_counter_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// gray_updown_counter_if : control and count bundle of gray_updown_counter
// Rev 1.0
// ----------------------------------------------------------------------------
interface gray_updown_counter_if #(
  parameter int WIDTH = 4
) ();

  logic             En;
  logic             Up;
  logic             Gray;
  logic             Load;
  logic [WIDTH-1:0] Load_val;
  logic [WIDTH-1:0] Q;
  logic             Tick;
  logic             Tc;

  modport master (output En, Up, Gray, Load, Load_val, input Q, Tick, Tc);
  modport slave  (input En, Up, Gray, Load, Load_val, output Q, Tick, Tc);

endinterface
`default_nettype wire

// File: rtl/gray_updown_counter_clk_enable_gen.sv
`default_nettype none
// ----------------------------------------------------------------------------
// clk_enable_gen : divide-by-DIV clock-enable prescaler, one-cycle step pulse
// Rev 1.0
// ----------------------------------------------------------------------------
module clk_enable_gen #(
  parameter int DIV = 100_000_000
) (
  input  logic Clk,
  input  logic Clr,
  input  logic En,
  output logic step
);

  localparam int                PCNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PCNT_W-1:0] c_LAST = PCNT_W'(DIV - 1);

  logic [PCNT_W-1:0] pcnt_q, pcnt_d;
  logic              w_wrap;

  always_comb begin
    w_wrap = (pcnt_q == c_LAST);
    pcnt_d = pcnt_q;
    if (En) begin
      pcnt_d = w_wrap ? '0 : pcnt_q + PCNT_W'(1);
    end
    step = En & w_wrap;
  end

  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      pcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/gray_updown_counter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// gray_updown_counter : prescaled up/down counter, Gray or binary output
// Rev 1.0
// ----------------------------------------------------------------------------
module gray_updown_counter
  import gray_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DIV   = 100_000_000
) (
  input  logic                         Clk,
  input  logic                         Clr,
  gray_updown_counter_if.slave         bus
);

  logic             step;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             tick_q, tick_d;
  logic             tc_q, tc_d;

  clk_enable_gen #(.DIV(DIV)) u_clk_enable_gen (
    .Clk  (Clk),
    .Clr  (Clr),
    .En   (bus.En),
    .step (step)
  );

  // Load outranks the step; a step landing on a Load edge is dropped.
  always_comb begin
    b_d    = b_q;
    tick_d = 1'b0;
    tc_d   = 1'b0;
    if (bus.Load) begin
      b_d = bus.Load_val;
    end else if (step) begin
      tick_d = 1'b1;
      if (bus.Up) begin
        b_d  = b_q + WIDTH'(1);
        tc_d = &b_q;
      end else begin
        b_d  = b_q - WIDTH'(1);
        tc_d = ~|b_q;
      end
    end
    q_d = bus.Gray ? WIDTH'(bin2gray(c_MAX_W'(b_d))) : b_d;
  end

  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      b_q    <= '0;
      q_q    <= '0;
      tick_q <= 1'b0;
      tc_q   <= 1'b0;
    end else begin
      b_q    <= b_d;
      q_q    <= q_d;
      tick_q <= tick_d;
      tc_q   <= tc_d;
    end
  end

  assign bus.Q    = q_q;
  assign bus.Tick = tick_q;
  assign bus.Tc   = tc_q;

endmodule
`default_nettype wire

// File: tb/tb_gray_updown_counter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_gray_updown_counter : scoreboard bench, WIDTH=4/DIV=4 and WIDTH=8/DIV=1
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_gray_updown_counter;
  import gray_pkg::*;

  localparam int c_DIV = 4;

  typedef struct packed {
    logic [3:0] q;
    logic       tick;
    logic       tc;
  } exp_t;

  logic Clk   = 1'b0;
  logic Clr   = 1'b1;
  logic Clr_b = 1'b1;

  always #5 Clk = ~Clk;

  gray_updown_counter_if #(.WIDTH(4)) bus_a ();
  gray_updown_counter_if #(.WIDTH(8)) bus_b ();

  gray_updown_counter #(.WIDTH(4), .DIV(c_DIV)) dut_a (
    .Clk (Clk),
    .Clr (Clr),
    .bus (bus_a.slave)
  );

  gray_updown_counter #(.WIDTH(8), .DIV(1)) dut_b (
    .Clk (Clk),
    .Clr (Clr_b),
    .bus (bus_b.slave)
  );

  int         n_checks = 0;
  int         n_errors = 0;
  exp_t       sb[$];
  logic [7:0] sb_b[$];
  int         m_pc = 0;
  logic [3:0] m_b  = 4'h0;
  logic       last_gray = 1'b0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: predict the next edge from current inputs, then compare.
  task automatic cyc_a();
    logic       stp;
    logic [3:0] nb;
    logic [3:0] prev_q;
    exp_t       e;
    stp = bus_a.En && (m_pc == c_DIV-1);
    e   = '0;
    nb  = m_b;
    if (bus_a.En) m_pc = (m_pc == c_DIV-1) ? 0 : m_pc + 1;
    if (bus_a.Load) begin
      nb = bus_a.Load_val;
    end else if (stp) begin
      e.tick = 1'b1;
      nb     = bus_a.Up ? m_b + 4'd1 : m_b - 4'd1;
      e.tc   = bus_a.Up ? (m_b == 4'hF) : (m_b == 4'h0);
    end
    m_b = nb;
    e.q = bus_a.Gray ? (nb ^ (nb >> 1)) : nb;
    sb.push_back(e);
    prev_q = bus_a.Q;
    @(posedge Clk); #1;
    e = sb.pop_front();
    chk("Q", 32'(bus_a.Q), 32'(e.q));
    chk("Tick", 32'(bus_a.Tick), 32'(e.tick));
    chk("Tc", 32'(bus_a.Tc), 32'(e.tc));
    if (bus_a.Gray && last_gray && bus_a.Tick)
      chk("gray_one_bit", 32'($countones(prev_q ^ bus_a.Q)), 32'd1);
    last_gray = bus_a.Gray;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  seq [17];
    logic [31:0] bin;
    int          idx;
    int          gap;
    int          guard;

    seq = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC,
            4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};

    bus_a.En = 1'b1; bus_a.Up = 1'b1; bus_a.Gray = 1'b1;
    bus_a.Load = 1'b0; bus_a.Load_val = 4'h0;
    bus_b.En = 1'b1; bus_b.Up = 1'b1; bus_b.Gray = 1'b0;
    bus_b.Load = 1'b0; bus_b.Load_val = 8'h00;

    // Outputs stay zero while Clr is held, even with En running.
    repeat (6) @(posedge Clk);
    #1;
    chk("rst_Q", 32'(bus_a.Q), 32'h0);
    chk("rst_Tick", 32'(bus_a.Tick), 32'h0);
    chk("rst_Tc", 32'(bus_a.Tc), 32'h0);
    Clr = 1'b0;
    last_gray = 1'b1;

    // Gray up count: full sequence, 4-cycle spacing, Tc only on 8->0.
    idx = 0; gap = 0;
    repeat (64) begin
      cyc_a();
      gap++;
      if (bus_a.Tick) begin
        idx++;
        chk("tick_spacing", 32'(gap), 32'd4);
        gap = 0;
        if (idx <= 16) begin
          chk("seq_Q", 32'(bus_a.Q), 32'(seq[idx]));
          chk("seq_Tc", 32'(bus_a.Tc), 32'(idx == 16));
        end
        bin = gray2bin(32'(bus_a.Q));
        chk("gray2bin", bin, 32'(m_b));
      end
    end
    chk("seq_steps", 32'(idx), 32'd16);

    // Down from zero: 0 -> 8 with Tc, then 8 -> 9.
    bus_a.Up = 1'b0;
    idx = 0;
    repeat (8) begin
      cyc_a();
      if (bus_a.Tick) begin
        idx++;
        chk("down_Q", 32'(bus_a.Q), (idx == 1) ? 32'h8 : 32'h9);
        chk("down_Tc", 32'(bus_a.Tc), 32'(idx == 1));
      end
    end
    chk("down_steps", 32'(idx), 32'd2);

    // Binary mode, Load coinciding with a step.
    bus_a.Gray = 1'b0;
    guard = 0;
    while (m_pc != c_DIV-1 && guard < 20) begin cyc_a(); guard++; end
    chk("reach_step", 32'(m_pc), 32'(c_DIV-1));
    bus_a.Load = 1'b1; bus_a.Load_val = 4'hA;
    cyc_a();
    chk("load_Q", 32'(bus_a.Q), 32'hA);
    chk("load_Tick", 32'(bus_a.Tick), 32'h0);
    bus_a.Load = 1'b0; bus_a.Up = 1'b1;
    repeat (4) cyc_a();
    chk("after_load_Q", 32'(bus_a.Q), 32'hB);

    // Freeze mid-interval with pcnt=2.
    guard = 0;
    while (m_pc != 2 && guard < 20) begin cyc_a(); guard++; end
    chk("reach_pc2", 32'(m_pc), 32'd2);
    bus_a.En = 1'b0;
    repeat (10) cyc_a();
    bus_a.En = 1'b1;
    cyc_a();
    chk("resume_no_tick", 32'(bus_a.Tick), 32'h0);
    cyc_a();
    chk("resume_tick", 32'(bus_a.Tick), 32'h1);

    // Async clear between edges with Q=7.
    guard = 0;
    while (m_b != 4'h7 && guard < 200) begin cyc_a(); guard++; end
    chk("reach7", 32'(bus_a.Q), 32'h7);
    #3 Clr = 1'b1;
    #1;
    chk("aclr_Q", 32'(bus_a.Q), 32'h0);
    chk("aclr_Tick", 32'(bus_a.Tick), 32'h0);
    chk("aclr_Tc", 32'(bus_a.Tc), 32'h0);
    @(posedge Clk); #1;
    chk("aclr_hold_Q", 32'(bus_a.Q), 32'h0);
    Clr = 1'b0;
    m_pc = 0; m_b = 4'h0;
    gap = 0; idx = 0;
    repeat (8) begin
      cyc_a();
      gap++;
      if (bus_a.Tick && idx == 0) begin
        idx = 1;
        chk("post_clr_first_step", 32'(gap), 32'd4);
      end
    end
    chk("post_clr_Q", 32'(bus_a.Q), 32'h2);

    // DIV=1, WIDTH=8: step every cycle, Tc on FF->00.
    @(posedge Clk); #1;
    Clr_b = 1'b0;
    for (int i = 1; i <= 520; i++) begin
      logic [7:0] e;
      sb_b.push_back(8'(i));
      @(posedge Clk); #1;
      e = sb_b.pop_front();
      chk("b_Q", 32'(bus_b.Q), 32'(e));
      chk("b_Tick", 32'(bus_b.Tick), 32'h1);
      chk("b_Tc", 32'(bus_b.Tc), 32'(e == 8'h00));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
